// File: rtl/ntt_sched_pkg.sv
// Shared types and address math for the NTT stage scheduler.
// Address helper works on ints so callers of any LOGN can truncate to their width.
package ntt_sched_pkg;

  localparam int MAX_LOGN = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic                vld;
    logic [MAX_LOGN-1:0] a;
    logic [MAX_LOGN-1:0] b;
  } wr_tag_t;

  // Cooley-Tukey in-place pairing: block g of span 2*len, offset k inside the block.
  function automatic void bfly_addr(input int logn, input int s, input int j,
                                    output int a, output int b, output int tw);
    int sh, len, g, k;
    sh  = logn - 1 - s;
    len = 1 << sh;
    g   = j >> sh;
    k   = j & (len - 1);
    a   = (g << (sh + 1)) + k;
    b   = a + len;
    tw  = (1 << s) + g;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth delay line with async active-low reset on every stage.
// Latency DEPTH cycles, no backpressure: shifts every clock.
module tag_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// Read/write-back scheduler for one NTT butterfly; a stage drains PIPE_LAT cycles before the next.
// Latency start->done LOGN*(N/2+PIPE_LAT)+1; writes trail reads by exactly PIPE_LAT.
// No backpressure unless SCHED_STALL_EN adds a stall input that holds issue in place.
module ntt_stage_sched #(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef SCHED_STALL_EN
  input  logic            stall,
`endif
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage_idx,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);
  import ntt_sched_pkg::*;

  localparam int HALF = 1 << (LOGN - 1);
  localparam int CW   = $clog2(PIPE_LAT + 1);

  state_t          state_q, state_n;
  logic [LOGN-1:0] stage_q, stage_n, j_q, j_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            rd_en_q, adv;
  int              a_n, b_n, tw_n;

`ifdef SCHED_STALL_EN
  assign adv   = ~stall;
  assign rd_en = rd_en_q & ~stall;
`else
  assign adv   = 1'b1;
  assign rd_en = rd_en_q;
`endif

  always_comb begin
    state_n = state_q;
    stage_n = stage_q;
    j_n     = j_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_n = ISSUE;
        stage_n = '0;
        j_n     = '0;
      end
      ISSUE: if (adv) begin
        if (j_q == LOGN'(HALF - 1)) begin
          state_n = DRAIN;
          cnt_n   = CW'(PIPE_LAT);
          j_n     = '0;
        end else begin
          j_n = j_q + LOGN'(1);
        end
      end
      DRAIN: begin
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (stage_q == LOGN'(LOGN - 1)) begin
            state_n = FIN;
          end else begin
            state_n = ISSUE;
            stage_n = stage_q + LOGN'(1);
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        stage_n = '0;
      end
      default: state_n = IDLE;
    endcase
    a_n  = 0;
    b_n  = 0;
    tw_n = 0;
    bfly_addr(LOGN, int'(stage_n), int'(j_n), a_n, b_n, tw_n);
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state_q <= state_n;
      stage_q <= stage_n;
      j_q     <= j_n;
      cnt_q   <= cnt_n;
      busy    <= (state_n == ISSUE) || (state_n == DRAIN);
      done    <= (state_n == FIN);
      rd_en_q <= (state_n == ISSUE);
      if (state_n == ISSUE) begin
        rd_addr_a <= LOGN'(a_n);
        rd_addr_b <= LOGN'(b_n);
        tw_addr   <= LOGN'(tw_n);
      end else begin
        rd_addr_a <= '0;
        rd_addr_b <= '0;
        tw_addr   <= '0;
      end
    end
  end

  assign stage_idx = stage_q;

  wr_tag_t tag_in, tag_out, unused_tag;

  always_comb begin
    tag_in             = '0;
    tag_in.vld         = rd_en;
    tag_in.a[LOGN-1:0] = rd_addr_a;
    tag_in.b[LOGN-1:0] = rd_addr_b;
  end

  tag_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH ($bits(wr_tag_t))
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tag_in),
    .dout  (tag_out)
  );

  assign wr_en      = tag_out.vld;
  assign wr_addr_a  = tag_out.a[LOGN-1:0];
  assign wr_addr_b  = tag_out.b[LOGN-1:0];
  assign unused_tag = tag_out;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Scoreboard bench for ntt_stage_sched: small config (LOGN=3, PIPE_LAT=2) checked per
// transaction, default config checked by totals; stall scenario when SCHED_STALL_EN is set.
module tb_ntt_stage_sched;

  localparam int LG = 3;
  localparam int PL = 2;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int s;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n, start, start_def, stall, stall_def;
  logic busy, done, rd_en, wr_en;
  logic [LG-1:0] stage_idx, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic busy_d, done_d, rd_en_d, wr_en_d;
  logic [7:0] stage_idx_d, rd_addr_a_d, rd_addr_b_d, tw_addr_d, wr_addr_a_d, wr_addr_b_d;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, c0 = 0, c0d = 0, exp_done = 0;
  int n_done = 0, done_seen = 0;
  int rd_cnt_d = 0, wr_cnt_d = 0, done_rel_d = -1;
  logic mon_on = 1'b0, def_on = 1'b0;
  txn_t rd_q[$], wr_q[$];

  ntt_stage_sched #(.LOGN(LG), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .stage_idx(stage_idx), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  ntt_stage_sched dut_def (
    .clk(clk), .rst_n(rst_n), .start(start_def),
`ifdef SCHED_STALL_EN
    .stall(stall_def),
`endif
    .busy(busy_d), .done(done_d), .stage_idx(stage_idx_d), .rd_en(rd_en_d),
    .rd_addr_a(rd_addr_a_d), .rd_addr_b(rd_addr_b_d), .tw_addr(tw_addr_d),
    .wr_en(wr_en_d), .wr_addr_a(wr_addr_a_d), .wr_addr_b(wr_addr_b_d)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected reads/writes of one transform; reads never land on stalled cycles.
  task automatic push_model(input int stall_lo, input int stall_hi);
    txn_t e;
    int c, len;
    rd_q.delete();
    wr_q.delete();
    c = 1;
    for (int s = 0; s < LG; s++) begin
      len = 1 << (LG - 1 - s);
      for (int g = 0; g < (1 << s); g++) begin
        for (int k = 0; k < len; k++) begin
          while (c >= stall_lo && c <= stall_hi) c++;
          e.cyc = c;
          e.a   = 2 * g * len + k;
          e.b   = e.a + len;
          e.tw  = (1 << s) + g;
          e.s   = s;
          rd_q.push_back(e);
          e.cyc = c + PL;
          wr_q.push_back(e);
          c++;
        end
      end
      c += PL;
    end
    exp_done  = c;
    n_done    = 0;
    done_seen = 0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      int rel;
      txn_t e;
      rel = cyc - c0;
      chk("busy", busy, (rel >= 1 && rel < exp_done));
      if (rd_en) begin
        if (rd_q.size() == 0) chk("rd_extra", rd_en, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cyc", rel, e.cyc);
          chk("rd_a", rd_addr_a, e.a);
          chk("rd_b", rd_addr_b, e.b);
          chk("tw", tw_addr, e.tw);
          chk("stage", stage_idx, e.s);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("wr_extra", wr_en, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_cyc", rel, e.cyc);
          chk("wr_a", wr_addr_a, e.a);
          chk("wr_b", wr_addr_b, e.b);
        end
      end
      if (done) begin
        n_done++;
        done_seen = 1;
        chk("done_cyc", rel, exp_done);
      end
    end
    if (def_on) begin
      if (rd_en_d) rd_cnt_d++;
      if (wr_en_d) wr_cnt_d++;
      if (done_d) done_rel_d = cyc - c0d;
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    c0     = cyc;
    mon_on = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_seen == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
    mon_on = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_def = 1'b0; stall = 1'b0; stall_def = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", {rd_addr_a, rd_addr_b, tw_addr, stage_idx, wr_addr_a, wr_addr_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full run
    push_model(-1, -2);
    do_start();
    wait_done("full", 60);

    // start pulsed again while busy must be ignored
    push_model(-1, -2);
    do_start();
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 60);

    // reset in cycle 8, held for two cycles
    push_model(-1, -2);
    do_start();
    repeat (7) @(posedge clk);
    #1;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", {rd_addr_a, rd_addr_b, tw_addr, stage_idx, wr_addr_a, wr_addr_b}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_wr_en", wr_en, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_rd_en", rd_en, 0);
      chk("post_rst_busy", busy, 0);
    end

    push_model(-1, -2);
    do_start();
    wait_done("after_rst", 60);

`ifdef SCHED_STALL_EN
    push_model(2, 3);
    do_start();
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stall = 1'b0;
    wait_done("stall", 60);
`endif

    // default parameters: totals only
    @(posedge clk); #1;
    c0d       = cyc;
    def_on    = 1'b1;
    start_def = 1'b1;
    @(posedge clk); #1;
    start_def = 1'b0;
    for (int i = 0; i < 1300 && done_rel_d < 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("def_done_cyc", done_rel_d, 8 * (128 + 12) + 1);
    chk("def_rd_cnt", rd_cnt_d, 1024);
    chk("def_wr_cnt", wr_cnt_d, 1024);
    chk("def_busy_end", busy_d, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
